// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-stage instruction fields and flush in, stall plus per-stage control fields out.
interface pipe_ctrl_unit_if #(
    parameter int OP_W    = 6,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 2
);
    logic               id_valid;
    logic [OP_W-1:0]    id_op_code;
    logic [RA_W-1:0]    id_rs;
    logic [RA_W-1:0]    id_rt;
    logic               flush;
    logic               stall;
    logic               ex_reg_dst;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [RA_W-1:0]    ex_rt;
    logic               mem_read;
    logic               mem_write;
    logic               mem_branch;
    logic               mem_half;
    logic               mem_half_unsigned;
    logic               wb_mem_to_reg;
    logic               wb_reg_write;
    logic               illegal;

    modport master (
        output id_valid, id_op_code, id_rs, id_rt, flush,
        input  stall, ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
               mem_read, mem_write, mem_branch, mem_half, mem_half_unsigned,
               wb_mem_to_reg, wb_reg_write, illegal
    );

    modport slave (
        input  id_valid, id_op_code, id_rs, id_rt, flush,
        output stall, ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
               mem_read, mem_write, mem_branch, mem_half, mem_half_unsigned,
               wb_mem_to_reg, wb_reg_write, illegal
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers, load-use stall, flush.
// Define PIPE_CTRL_ILLEGAL_TRAP_EN to build the sticky illegal-opcode trap; otherwise illegal is tied 0.
module pipe_ctrl_unit #(
    parameter int OP_W    = 6,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_unit_if.slave bus
);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2B);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_LH    = OP_W'('h21);
    localparam logic [OP_W-1:0] OP_LHU   = OP_W'('h25);

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               half;
        logic               half_unsigned;
        logic               mem_to_reg;
        logic               reg_write;
    } ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic half;
        logic half_unsigned;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    ctrl_t           dec;
    ctrl_t           idex;
    logic [RA_W-1:0] idex_rt;
    mem_ctrl_t       exmem;
    wb_ctrl_t        memwb;
    logic            stall_int;

    always_comb begin
        dec = '0;
        case (bus.id_op_code)
            OP_RTYPE: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(2'b10);
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW, OP_LH, OP_LHU: begin
                dec.alu_src       = 1'b1;
                dec.mem_to_reg    = 1'b1;
                dec.reg_write     = 1'b1;
                dec.mem_read      = 1'b1;
                dec.half          = (bus.id_op_code != OP_LW);
                dec.half_unsigned = (bus.id_op_code == OP_LHU);
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALUOP_W'(2'b01);
            end
            default: ;
        endcase
    end

    // A taken branch kills the younger load anyway, so a flush suppresses the stall.
    assign stall_int = idex.mem_read && (idex_rt != '0) && bus.id_valid && !bus.flush &&
                       ((idex_rt == bus.id_rs) || (idex_rt == bus.id_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex    <= '0;
            idex_rt <= '0;
            exmem   <= '0;
            memwb   <= '0;
        end else begin
            memwb <= '{exmem.mem_to_reg, exmem.reg_write};
            if (bus.flush) begin
                idex    <= '0;
                idex_rt <= '0;
                exmem   <= '0;
            end else begin
                exmem <= '{idex.mem_read, idex.mem_write, idex.branch, idex.half,
                           idex.half_unsigned, idex.mem_to_reg, idex.reg_write};
                if (stall_int || !bus.id_valid) begin
                    idex    <= '0;
                    idex_rt <= '0;
                end else begin
                    idex    <= dec;
                    idex_rt <= bus.id_rt;
                end
            end
        end
    end

    assign bus.stall             = stall_int;
    assign bus.ex_reg_dst        = idex.reg_dst;
    assign bus.ex_alu_src        = idex.alu_src;
    assign bus.ex_alu_op         = idex.alu_op;
    assign bus.ex_rt             = idex_rt;
    assign bus.mem_read          = exmem.mem_read;
    assign bus.mem_write         = exmem.mem_write;
    assign bus.mem_branch        = exmem.branch;
    assign bus.mem_half          = exmem.half;
    assign bus.mem_half_unsigned = exmem.half_unsigned;
    assign bus.wb_mem_to_reg     = memwb.mem_to_reg;
    assign bus.wb_reg_write      = memwb.reg_write;

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    logic id_legal;
    logic illegal_q;

    always_comb begin
        id_legal = 1'b0;
        case (bus.id_op_code)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_LH, OP_LHU: id_legal = 1'b1;
            default: id_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (bus.id_valid && !id_legal && !stall_int && !bus.flush) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios then random traffic against an instruction-slot reference model.
module tb_pipe_ctrl_unit;
    logic clk;
    logic rst;

    pipe_ctrl_unit_if bus ();

    pipe_ctrl_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // legal, reg_dst, alu_src, alu_op[1:0], mem_read, mem_write, branch, half, half_u, mem_to_reg, reg_write
    typedef struct packed {
        logic       legal;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       half;
        logic       half_u;
        logic       mem_to_reg;
        logic       reg_write;
    } ref_t;

    typedef struct {
        bit         live;
        logic [5:0] op;
        logic [4:0] rt;
    } slot_t;

    ref_t  tab [64];
    slot_t s_ex, s_mem, s_wb;
    slot_t empty_slot;
    bit    ill_flag;
    int    n_cmp;
    int    n_err;

    logic [5:0] legal_ops [7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ref_t slot_ctrl(input slot_t s);
        return s.live ? tab[s.op] : ref_t'(0);
    endfunction

    task automatic check_outputs();
        ref_t ce, cm, cw;
        ce = slot_ctrl(s_ex);
        cm = slot_ctrl(s_mem);
        cw = slot_ctrl(s_wb);
        chk("ex", {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_alu_op, bus.ex_rt},
                  {ce.reg_dst, ce.alu_src, ce.alu_op, (s_ex.live ? s_ex.rt : 5'd0)});
        chk("mem", {bus.mem_read, bus.mem_write, bus.mem_branch, bus.mem_half, bus.mem_half_unsigned},
                   {cm.mem_read, cm.mem_write, cm.branch, cm.half, cm.half_u});
        chk("wb", {bus.wb_mem_to_reg, bus.wb_reg_write}, {cw.mem_to_reg, cw.reg_write});
        chk("illegal", bus.illegal, ill_flag);
    endtask

    task automatic do_cycle(input bit v, input logic [5:0] op, input logic [4:0] rs,
                            input logic [4:0] rt, input bit fl, output bit stalled);
        bit exp_stall;
        ref_t e;
        @(negedge clk);
        bus.id_valid   = v;
        bus.id_op_code = op;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.flush      = fl;
        #2;
        e = slot_ctrl(s_ex);
        exp_stall = !fl && e.mem_read && (s_ex.rt != 0) && v && (s_ex.rt == rs || s_ex.rt == rt);
        chk("stall", bus.stall, exp_stall);
        @(posedge clk);
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        if (v && !tab[op].legal && !exp_stall && !fl) ill_flag = 1'b1;
`endif
        s_wb = s_mem;
        if (fl) begin
            s_mem = empty_slot;
            s_ex  = empty_slot;
        end else begin
            s_mem = s_ex;
            if (v && !exp_stall) begin
                s_ex.live = 1'b1;
                s_ex.op   = op;
                s_ex.rt   = rt;
            end else begin
                s_ex = empty_slot;
            end
        end
        #1;
        check_outputs();
        stalled = exp_stall;
    endtask

    // Issue one instruction, re-presenting it while the pipe stalls.
    task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input bit fl);
        bit st;
        int guard;
        guard = 0;
        do_cycle(1'b1, op, rs, rt, fl, st);
        while (st && guard < 4) begin
            do_cycle(1'b1, op, rs, rt, 1'b0, st);
            guard++;
        end
        chk("stall_len", st, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        s_ex = empty_slot; s_mem = empty_slot; s_wb = empty_slot;
        ill_flag = 1'b0;
        check_outputs();
        chk("stall_rst", bus.stall, 1'b0);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit st;
        bit v, fl;
        logic [5:0] op;
        logic [4:0] rs, rt;

        n_cmp = 0;
        n_err = 0;
        ill_flag = 1'b0;
        empty_slot.live = 1'b0;
        empty_slot.op   = 6'd0;
        empty_slot.rt   = 5'd0;
        s_ex = empty_slot; s_mem = empty_slot; s_wb = empty_slot;

        for (int i = 0; i < 64; i++) tab[i] = '0;
        tab[6'h00] = ref_t'(12'b1_1_0_10_0_0_0_0_0_0_1);
        tab[6'h08] = ref_t'(12'b1_0_1_00_0_0_0_0_0_0_1);
        tab[6'h23] = ref_t'(12'b1_0_1_00_1_0_0_0_0_1_1);
        tab[6'h2B] = ref_t'(12'b1_0_1_00_0_1_0_0_0_0_0);
        tab[6'h04] = ref_t'(12'b1_0_0_01_0_0_1_0_0_0_0);
        tab[6'h21] = ref_t'(12'b1_0_1_00_1_0_0_1_0_1_1);
        tab[6'h25] = ref_t'(12'b1_0_1_00_1_0_0_1_1_1_1);
        legal_ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h21, 6'h25};

        bus.id_valid   = 1'b0;
        bus.id_op_code = '0;
        bus.id_rs      = '0;
        bus.id_rt      = '0;
        bus.flush      = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // decode sweep, no register overlap
        issue(6'h00, 5'd1, 5'd2, 1'b0);
        issue(6'h08, 5'd3, 5'd4, 1'b0);
        issue(6'h23, 5'd5, 5'd6, 1'b0);
        issue(6'h2B, 5'd7, 5'd8, 1'b0);
        issue(6'h04, 5'd9, 5'd10, 1'b0);
        issue(6'h21, 5'd11, 5'd12, 1'b0);
        issue(6'h25, 5'd13, 5'd14, 1'b0);
        repeat (3) do_cycle(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, st);
        chk("lhu_mem", {bus.mem_read, bus.mem_write, bus.mem_half, bus.mem_half_unsigned}, 4'd0);

        // load-use with rt=5, then with rt=0
        issue(6'h23, 5'd1, 5'd5, 1'b0);
        do_cycle(1'b1, 6'h00, 5'd5, 5'd2, 1'b0, st);
        chk("lu_stall", st, 1'b1);
        do_cycle(1'b1, 6'h00, 5'd5, 5'd2, 1'b0, st);
        chk("lu_once", st, 1'b0);
        issue(6'h23, 5'd1, 5'd0, 1'b0);
        do_cycle(1'b1, 6'h00, 5'd0, 5'd3, 1'b0, st);
        chk("lu_r0", st, 1'b0);

        // flush with beq in MEM, addi in EX, lw in ID
        issue(6'h04, 5'd1, 5'd2, 1'b0);
        issue(6'h08, 5'd3, 5'd4, 1'b0);
        do_cycle(1'b1, 6'h23, 5'd6, 5'd7, 1'b1, st);
        chk("fl_wb_beq", {bus.wb_reg_write, bus.mem_read, bus.ex_alu_src}, 3'd0);
        // flush coinciding with a load-use pair
        issue(6'h23, 5'd1, 5'd5, 1'b0);
        do_cycle(1'b1, 6'h00, 5'd5, 5'd5, 1'b1, st);
        chk("fl_no_stall", st, 1'b0);

        // unlisted opcode, then legal traffic
        issue(6'h3F, 5'd1, 5'd2, 1'b0);
        issue(6'h08, 5'd3, 5'd4, 1'b0);
        issue(6'h00, 5'd1, 5'd2, 1'b0);

        // invalid lw never reaches any stage
        repeat (3) do_cycle(1'b0, 6'h23, 5'd1, 5'd9, 1'b0, st);
        chk("inv_lw", {bus.ex_rt, bus.mem_read, bus.wb_mem_to_reg}, 7'd0);

        // reset while lw sits in EX, then resume
        issue(6'h23, 5'd1, 5'd9, 1'b0);
        async_reset();
        issue(6'h08, 5'd2, 5'd3, 1'b0);

        st = 1'b0;
        v = 1'b0; op = '0; rs = '0; rt = '0;
        for (int i = 0; i < 600; i++) begin
            if (!st) begin
                int k;
                k  = $urandom_range(0, 8);
                op = (k < 7) ? legal_ops[k] : 6'($urandom_range(0, 63));
                v  = ($urandom_range(0, 99) < 85);
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
            end
            fl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                st = 1'b0;
            end else begin
                do_cycle(v, op, rs, rt, fl, st);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
